// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall vector, exception/ERET flush sequencing, stall watchdog.
// Optional perf counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] exc_cause_o,
  output logic        stall_timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  typedef enum logic {S_RUN, S_FLUSH_HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_timeout_q, stall_timeout_d;
  logic [31:0] exc_cause_q, exc_cause_d;
  logic        stalled;

  always_comb begin
    state_d     = state_q;
    stall       = 6'b000000;
    flush       = 1'b0;
    new_pc      = 32'h0;
    exc_cause_d = exc_cause_q;
    if (!rst) begin
      // The hold state ignores excepttype_i so a stale mem-stage exception cannot flush twice.
      if (state_q == S_RUN && excepttype_i != 32'h0) begin
        flush       = 1'b1;
        state_d     = S_FLUSH_HOLD;
        exc_cause_d = excepttype_i;
        case (excepttype_i)
          32'h0000_0001: new_pc = INT_VECTOR;
          32'h0000_000E: new_pc = cp0_epc_i;
          default:       new_pc = EXC_VECTOR;
        endcase
      end else begin
        state_d = S_RUN;
        if (stallreq_from_mem)     stall = 6'b011111;
        else if (stallreq_from_ex) stall = 6'b001111;
        else if (stallreq_from_id) stall = 6'b000111;
      end
    end
  end

  always_comb begin
    stalled         = (stall != 6'b000000);
    stall_cnt_d     = 16'h0;
    stall_timeout_d = stall_timeout_q;
    if (stalled) begin
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
      if (stall_cnt_q == STALL_TIMEOUT - 16'd1) stall_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RUN;
      stall_cnt_q     <= 16'h0;
      stall_timeout_q <= 1'b0;
      exc_cause_q     <= 32'h0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
      exc_cause_q     <= exc_cause_d;
    end
  end

  assign exc_cause_o     = exc_cause_q;
  assign stall_timeout_o = stall_timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = stalled ? perf_stall_q + 32'd1 : perf_stall_q;
    perf_flush_d = flush   ? perf_flush_q + 32'd1 : perf_flush_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_cnt_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed steps push expected outputs, a monitor compares each cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_id, sr_ex, sr_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, exc_cause;
  logic        stall_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INT_VECTOR   (32'h0000_0020),
    .EXC_VECTOR   (32'h0000_0040),
    .STALL_TIMEOUT(16'd4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (sr_id),
    .stallreq_from_ex (sr_ex),
    .stallreq_from_mem(sr_mem),
    .excepttype_i     (excepttype),
    .cp0_epc_i        (cp0_epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .exc_cause_o      (exc_cause),
    .stall_timeout_o  (stall_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_stall_cycles_o(perf_stall),
    .perf_flush_cnt_o   (perf_flush)
`endif
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [5:0]  stall;
    logic        flush;
    logic        pc_chk;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", name, id, act, req);
    end
  endtask

  task automatic step(input int id, input logic r, input logic m, input logic e, input logic i,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] e_stall, input logic e_flush, input logic e_pcchk,
                      input logic [31:0] e_pc, input logic [31:0] e_cause, input logic e_tmo);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; sr_mem = m; sr_ex = e; sr_id = i; excepttype = exc; cp0_epc = epc;
    x.id = 8'(id); x.stall = e_stall; x.flush = e_flush; x.pc_chk = e_pcchk;
    x.pc = e_pc; x.cause = e_cause; x.tmo = e_tmo;
    exp_q.push_back(x);
    $display("step %0d: rst=%0b mem=%0b ex=%0b id=%0b exc=%h epc=%h", id, r, m, e, i, exc, epc);
  endtask

  // Monitor: the controller answers every cycle, so each pending entry is checked at the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", int'(e.id), {26'h0, stall}, {26'h0, e.stall});
        check("flush", int'(e.id), {31'h0, flush}, {31'h0, e.flush});
        if (e.pc_chk) check("new_pc", int'(e.id), new_pc, e.pc);
        check("exc_cause", int'(e.id), exc_cause, e.cause);
        check("stall_timeout", int'(e.id), {31'h0, stall_timeout}, {31'h0, e.tmo});
      end
    end
  end

  initial begin
    rst = 1'b1; sr_id = 1'b1; sr_ex = 1'b1; sr_mem = 1'b1;
    excepttype = 32'h1; cp0_epc = 32'h0;

    // reset overrides everything
    step(1, 1, 1, 1, 1, 32'h1, 32'h0, 6'b000000, 0, 1, 32'h0, 32'h0, 0);
    step(2, 1, 1, 1, 1, 32'h1, 32'h0, 6'b000000, 0, 1, 32'h0, 32'h0, 0);
    // stall priority
    step(3, 0, 0, 0, 1, 32'h0, 32'h0, 6'b000111, 0, 0, 32'h0, 32'h0, 0);
    step(4, 0, 0, 1, 1, 32'h0, 32'h0, 6'b001111, 0, 0, 32'h0, 32'h0, 0);
    step(5, 0, 1, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 32'h0, 32'h0, 0);
    step(6, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h0, 0);
    // exception held 3 cycles with ex stall: flush, hold, flush
    step(7, 0, 0, 1, 0, 32'h8, 32'h0, 6'b000000, 1, 1, 32'h40, 32'h0, 0);
    step(8, 0, 0, 1, 0, 32'h8, 32'h0, 6'b001111, 0, 0, 32'h0, 32'h8, 0);
    step(9, 0, 0, 1, 0, 32'h8, 32'h0, 6'b000000, 1, 1, 32'h40, 32'h8, 0);
    step(10, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h8, 0);
    // ERET, interrupt, other nonzero cause
    step(11, 0, 0, 0, 0, 32'hE, 32'h1234, 6'b000000, 1, 1, 32'h1234, 32'h8, 0);
    step(12, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'hE, 0);
    step(13, 0, 0, 0, 0, 32'h1, 32'h0, 6'b000000, 1, 1, 32'h20, 32'hE, 0);
    step(14, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h1, 0);
    step(15, 0, 0, 0, 0, 32'h5, 32'h0, 6'b000000, 1, 1, 32'h40, 32'h1, 0);
    step(16, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h5, 0);
    // watchdog: sets after the 4th consecutive stalled cycle, sticky
    for (int k = 17; k <= 21; k++)
      step(k, 0, 1, 0, 0, 32'h0, 32'h0, 6'b011111, 0, 0, 32'h0, 32'h5, k == 21);
    step(22, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h5, 1);
    step(23, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h5, 1);
    step(24, 1, 1, 0, 0, 32'h1, 32'h0, 6'b000000, 0, 1, 32'h0, 32'h5, 1);
    step(25, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h0, 0);
    // reset while in the flush-hold state
    step(26, 0, 0, 0, 0, 32'hA, 32'h0, 6'b000000, 1, 1, 32'h40, 32'h0, 0);
    step(27, 1, 0, 0, 0, 32'hA, 32'h0, 6'b000000, 0, 1, 32'h0, 32'hA, 0);
    step(28, 0, 0, 0, 0, 32'hA, 32'h0, 6'b000000, 1, 1, 32'h40, 32'h0, 0);
    step(29, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'hA, 0);
    // 10 stalled cycles then a second flush since the last reset
    for (int k = 30; k <= 39; k++)
      step(k, 0, 1, 0, 0, 32'h0, 32'h0, 6'b011111, 0, 0, 32'h0, 32'hA, k >= 34);
    step(40, 0, 0, 0, 0, 32'h8, 32'h0, 6'b000000, 1, 1, 32'h40, 32'hA, 1);
    step(41, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 32'h0, 32'h8, 1);

`ifdef STALL_PERF_CNT_EN
    @(negedge clk);
    check("perf_stall_cycles", 41, perf_stall, 32'd10);
    check("perf_flush_cnt", 41, perf_flush, 32'd2);
`endif

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
